// File: rtl/tetris_pkg.sv
// -----------------------------------------------------------------------------
// tetris_pkg
// Shared definitions for the tetris core and the screen scanner.
//   SCREEN_X     : pixels per row
//   SCREEN_Y     : rows per frame
//   row_t        : one row of pixels
//   row_idx_t    : row index
//   scan_state_e : screen scanner FSM states
// -----------------------------------------------------------------------------
package tetris_pkg;

  localparam int SCREEN_X = 10;
  localparam int SCREEN_Y = 20;

  typedef logic [SCREEN_X-1:0]         row_t;
  typedef logic [$clog2(SCREEN_Y)-1:0] row_idx_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } scan_state_e;

endpackage

// File: rtl/screen_scanner_row_mux.sv
// -----------------------------------------------------------------------------
// row_mux
// Combinational selection of one row out of a flat SCREEN_X*SCREEN_Y bitmap.
// Row y occupies flat_i[y*SCREEN_X +: SCREEN_X].
// Ports:
//   flat_i : flat bitmap
//   idx_i  : row to select (indices >= SCREEN_Y return 0)
//   row_o  : selected row
// -----------------------------------------------------------------------------
module row_mux #(
  parameter int  SCREEN_X = tetris_pkg::SCREEN_X,
  parameter int  SCREEN_Y = tetris_pkg::SCREEN_Y,
  localparam int ROW_W    = $clog2(SCREEN_Y)
) (
  input  logic [SCREEN_X*SCREEN_Y-1:0] flat_i,
  input  logic [ROW_W-1:0]             idx_i,
  output logic [SCREEN_X-1:0]          row_o
);

  logic [SCREEN_X-1:0] rows [SCREEN_Y];

  for (genvar gi = 0; gi < SCREEN_Y; gi++) begin : g_rows
    assign rows[gi] = flat_i[gi*SCREEN_X +: SCREEN_X];
  end

  always_comb begin
    row_o = '0;
    for (int y = 0; y < SCREEN_Y; y++) begin
      if (idx_i == ROW_W'(y)) begin
        row_o = rows[y];
      end
    end
  end

endmodule

// File: rtl/screen_scanner.sv
// -----------------------------------------------------------------------------
// screen_scanner
// Snapshots the game's flat screen bitmap on a frame request and streams it
// out one row per transfer (valid/ready), row 0 first.  Because only the
// snapshot is streamed, game updates during a scan never tear a frame.
//
// Optional build macro: SCREEN_SCANNER_DIRTY_ROWS_EN
//   When defined, the last transferred value of every row is remembered and
//   rows that are unchanged since the last completed frame are skipped (one
//   idle cycle each).  The first frame after reset always sends every row.
//
// Ports:
//   clock      : system clock, rising edge
//   reset      : synchronous, active-low reset
//   screen     : flat bitmap, row y = screen[y*SCREEN_X +: SCREEN_X]
//   frame_req  : one-cycle request to capture and scan a frame
//   row_data   : pixels of the presented row (0 when row_valid=0)
//   row_index  : index of the presented row (0 when row_valid=0)
//   row_valid  : a row is presented
//   row_ready  : sink accepts the presented row this cycle
//   busy       : scan in progress
//   frame_done : one-cycle pulse after the last row of a frame
//   overrun    : sticky, frame_req seen while busy
// -----------------------------------------------------------------------------
module screen_scanner #(
  parameter int  SCREEN_X = tetris_pkg::SCREEN_X,
  parameter int  SCREEN_Y = tetris_pkg::SCREEN_Y,
  localparam int ROW_W    = $clog2(SCREEN_Y)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [SCREEN_X*SCREEN_Y-1:0] screen,
  input  logic                         frame_req,
  output logic [SCREEN_X-1:0]          row_data,
  output logic [ROW_W-1:0]             row_index,
  output logic                         row_valid,
  input  logic                         row_ready,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  import tetris_pkg::*;

  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(SCREEN_Y - 1);

  scan_state_e                  state_q, state_d;
  logic [SCREEN_X*SCREEN_Y-1:0] snap_q, snap_d;
  logic [ROW_W-1:0]             cnt_q, cnt_d;
  logic                         overrun_q, overrun_d;
  logic [SCREEN_X-1:0]          snap_row;
  logic                         row_dirty;

  row_mux #(
    .SCREEN_X (SCREEN_X),
    .SCREEN_Y (SCREEN_Y)
  ) u_snap_mux (
    .flat_i (snap_q),
    .idx_i  (cnt_q),
    .row_o  (snap_row)
  );

`ifdef SCREEN_SCANNER_DIRTY_ROWS_EN
  logic [SCREEN_X*SCREEN_Y-1:0] prev_q, prev_d;
  logic                         prev_valid_q, prev_valid_d;
  logic [SCREEN_X-1:0]          prev_row;

  row_mux #(
    .SCREEN_X (SCREEN_X),
    .SCREEN_Y (SCREEN_Y)
  ) u_prev_mux (
    .flat_i (prev_q),
    .idx_i  (cnt_q),
    .row_o  (prev_row)
  );

  // Until one full frame has completed, prev holds nothing trustworthy.
  assign row_dirty = !prev_valid_q || (snap_row != prev_row);

  always_comb begin
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q || (state_q == ST_DONE);
    for (int y = 0; y < SCREEN_Y; y++) begin
      if (row_valid && row_ready && (cnt_q == ROW_W'(y))) begin
        prev_d[y*SCREEN_X +: SCREEN_X] = snap_row;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
    end else begin
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
    end
  end
`else
  assign row_dirty = 1'b1;
`endif

  always_comb begin
    state_d   = state_q;
    snap_d    = snap_q;
    cnt_d     = cnt_q;
    overrun_d = overrun_q;
    row_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (frame_req) begin
          snap_d  = screen;
          cnt_d   = '0;
          state_d = ST_SCAN;
        end
      end
      ST_SCAN: begin
        overrun_d = overrun_q | frame_req;
        row_valid = row_dirty;
        // Advance on a transfer, or unconditionally on a skipped clean row.
        if (!row_dirty || row_ready) begin
          if (cnt_q == LAST_ROW) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ST_DONE: begin
        overrun_d = overrun_q | frame_req;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      snap_q    <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      snap_q    <= snap_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  assign row_data   = row_valid ? snap_row : '0;
  assign row_index  = row_valid ? cnt_q : '0;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = (state_q == ST_DONE);
  assign overrun    = overrun_q;

endmodule
